// File: rtl/data_array_nway.sv
`default_nettype none
// ============================================================================
// Module   : data_array_nway
// Brief    : Parametrised N-way cache data array. WAYS x SETS x WORDS words
//            with binary set/word/way indexing, a registered 1-cycle read
//            port with valid strobe, and a block-refill sequencer that
//            writes a whole block from memory one word per fill_valid beat.
//            Optional per-word even parity is enabled by defining the macro
//            DATA_ARRAY_PARITY_EN; without it rd_perr is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module data_array_nway #(
    parameter  int DATA_W = 16,
    parameter  int SETS   = 64,
    parameter  int WORDS  = 8,
    parameter  int WAYS   = 2,
    localparam int SET_W  = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WORD_W = $clog2(WORDS),
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    // hit-path request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [SET_W-1:0]  req_set,
    input  logic [WORD_W-1:0] req_word,
    input  logic [WAY_W-1:0]  req_way,
    input  logic [DATA_W-1:0] req_wdata,
    // read response
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    // refill path
    input  logic              fill_start,
    input  logic [SET_W-1:0]  fill_set,
    input  logic [WAY_W-1:0]  fill_way,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    // parity error on current rd_data
    output logic              rd_perr
);

    // Word counter value of the final beat of a refill
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_cnt;
    logic [SET_W-1:0]    r_fill_set;
    logic [WAY_W-1:0]    r_fill_way;

    // Storage: must be flops since every word is cleared by reset
    logic [DATA_W-1:0]   r_mem [WAYS][SETS][WORDS];
`ifdef DATA_ARRAY_PARITY_EN
    logic                r_par [WAYS][SETS][WORDS];
`endif

    logic                w_req_fire;
    logic                w_hit_wr;
    logic                w_hit_rd;
    logic                w_req_in_range;
    logic                w_fill_in_range;
    logic                w_fill_wr;
    logic                w_wr_en;
    logic [WAY_W-1:0]    w_wr_way;
    logic [SET_W-1:0]    w_wr_set;
    logic [WORD_W-1:0]   w_wr_word;
    logic [DATA_W-1:0]   w_wr_data;

    // A refill start always wins over a same-cycle hit request, and no hit
    // request is taken while a block is being refilled.
    assign req_ready  = (r_state == S_IDLE) && !fill_start;
    assign w_req_fire = req_valid && req_ready;
    assign w_hit_wr   = w_req_fire && req_write;
    assign w_hit_rd   = w_req_fire && !req_write;
    assign w_fill_wr  = (r_state == S_FILL) && fill_valid;

    // Out-of-range indices never touch storage; reads of them return zero.
    assign w_req_in_range  = (int'(req_way) < WAYS) &&
                             (int'(req_set) < SETS) &&
                             (int'(req_word) < WORDS);
    assign w_fill_in_range = (int'(r_fill_way) < WAYS) &&
                             (int'(r_fill_set) < SETS);

    // Select the single write source for this cycle (hit and fill writes are
    // mutually exclusive because hits are only accepted in IDLE).
    always_comb begin
        w_wr_way  = req_way;
        w_wr_set  = req_set;
        w_wr_word = req_word;
        w_wr_data = req_wdata;
        w_wr_en   = w_hit_wr && w_req_in_range;
        if (w_fill_wr) begin
            w_wr_way  = r_fill_way;
            w_wr_set  = r_fill_set;
            w_wr_word = r_cnt;
            w_wr_data = fill_data;
            w_wr_en   = w_fill_in_range;
        end
    end

    // Refill sequencer: latch block address on start, count beats, pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_fill_set <= '0;
            r_fill_way <= '0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fill_start) begin
                        r_state    <= S_FILL;
                        r_cnt      <= '0;
                        r_fill_set <= fill_set;
                        r_fill_way <= fill_way;
                        fill_busy  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (fill_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            r_state   <= S_IDLE;
                            r_cnt     <= '0;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    fill_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: clear everything on reset, otherwise one word per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int d = 0; d < WORDS; d++) begin
                        r_mem[w][s][d] <= '0;
`ifdef DATA_ARRAY_PARITY_EN
                        r_par[w][s][d] <= 1'b0;
`endif
                    end
                end
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_way][w_wr_set][w_wr_word] <= w_wr_data;
`ifdef DATA_ARRAY_PARITY_EN
            // Even parity: stored bit makes the total count of ones even
            r_par[w_wr_way][w_wr_set][w_wr_word] <= ^w_wr_data;
`endif
        end
    end

    // Registered read port; rd_data holds its value between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= w_hit_rd;
            if (w_hit_rd) begin
                rd_data <= w_req_in_range ? r_mem[req_way][req_set][req_word]
                                          : '0;
            end
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    // Parity check travels with the read; zero whenever rd_valid is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_perr <= 1'b0;
        end else begin
            rd_perr <= w_hit_rd && w_req_in_range &&
                       ((^r_mem[req_way][req_set][req_word]) ^
                        r_par[req_way][req_set][req_word]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/data_array_nway.md
# data_array_nway

Parametrised N-way cache data array: successor to the single-way, one-hot-indexed data array used by the I- and D-caches. It stores `WAYS` ways of `SETS` blocks of `WORDS` words each. It takes binary-encoded set/word/way indices and returns registered read data with a valid strobe. It also contains a block-refill sequencer that writes a whole block from memory word-by-word. It sits between the cache controller (hit path) and the memory refill path.

## Interface
Parameters:
- `DATA_W`, 16, word width in bits
- `SETS`, 64, sets per way (need not be a power of 2)
- `WORDS`, 8, words per block (≥2)
- `WAYS`, 2, ways (≥1)
- Derived: `SET_W=$clog2(SETS)`, `WORD_W=$clog2(WORDS)`, `WAY_W=max(1,$clog2(WAYS))`

Ports:
- `clk` in 1: the single clock, rising edge
- `rst` in 1: asynchronous, active-low reset (asserted at 0)
- `req_valid` in 1: hit-path request
- `req_ready` out 1: array can accept a hit-path request this cycle
- `req_write` in 1: 1 = write, 0 = read
- `req_set` in SET_W; `req_word` in WORD_W; `req_way` in WAY_W: request address
- `req_wdata` in DATA_W: write data
- `rd_valid` out 1: `rd_data` is valid this cycle
- `rd_data` out DATA_W: read data
- `fill_start` in 1: begin refill of block (`fill_set`, `fill_way`)
- `fill_set` in SET_W; `fill_way` in WAY_W: sampled when `fill_start` is accepted
- `fill_valid` in 1: `fill_data` carries the next refill word
- `fill_data` in DATA_W: refill word, delivered in ascending word order
- `fill_busy` out 1: sequencer is in FILL
- `fill_done` out 1: single-cycle pulse after the last word is written
- `rd_perr` out 1: parity error on the current `rd_data` (see Configuration)

## Operation
- **Storage:** `WAYS*SETS*WORDS` words. All words are cleared to 0 on reset.
- **Sequencer states:** IDLE, FILL.
  - IDLE→FILL when `fill_start=1`. This latches `fill_set`/`fill_way` and clears the word counter `cnt` to 0.
  - In FILL, each cycle with `fill_valid=1` writes `fill_data` to (latched way, latched set, `cnt`) and increments `cnt`.
  - The write with `cnt==WORDS-1` returns the FSM to IDLE and sets `fill_done`=1 for the next cycle.
  - `fill_start` is ignored while in FILL.
- **Request acceptance:** `req_ready = (state==IDLE) && !fill_start`. A refill always wins over a same-cycle request.
- **Accepted write** (`req_valid && req_ready && req_write`): updates one word at the clock edge. No read response.
- **Accepted read:** registered, 1-cycle latency. `rd_valid`=1 and `rd_data` are presented in the next cycle.
- **Idle read data:** when no read was accepted in the prior cycle, `rd_valid`=0 and `rd_data` holds its last value.
- **Out-of-range indices** (set ≥ `SETS`, way ≥ `WAYS`):
  - A write is dropped.
  - A read returns `rd_valid`=1 with `rd_data`=0.
  - A refill is accepted, but its writes are dropped.
- **Counter wrap:** `cnt` is WORD_W bits. The FSM exits on `WORDS-1`, so `cnt` never wraps inside FILL.
- **Reset (any state, including mid-fill):** FSM→IDLE, `cnt`=0, storage cleared. Partial refill data is discarded.

## Timing
- **Reset values:** `req_ready`=1 (unless `fill_start`), `rd_valid`=0, `rd_data`=0, `fill_busy`=0, `fill_done`=0, `rd_perr`=0.
- **Read latency:** 1 cycle.
- **Write-then-read to the same word:** a read accepted in cycle N+1 returns the data written in cycle N. No same-cycle forwarding is needed, because only one request is accepted per cycle.
- **Refill duration:** at least `WORDS` cycles. `fill_valid` gaps stall the counter.
  - `fill_busy`=1 from the cycle after `fill_start` through the cycle of the last word.
  - `fill_done` is asserted in the following cycle, with `req_ready`=1 in that same cycle.
- **Read during refill:** a read accepted in the cycle before `fill_start` completes normally in the cycle `fill_start` is accepted.

## Configuration
- **`DATA_ARRAY_PARITY_EN` defined:**
  - Each stored word carries one extra even-parity bit, computed on every write (hit path and refill).
  - On a read, `rd_perr` = recomputed parity XOR stored parity. It is valid with `rd_valid` and is 0 otherwise.
- **Not defined:** no parity storage; `rd_perr` is tied to 0.

## Test plan
- **Reset:** release `rst` → `rd_valid`=0, `fill_busy`=0, `req_ready`=1. Read way1/set63/word7 → `rd_data`=0x0000 next cycle.
- **Write then read:** write 0xBEEF to way1/set5/word3, then read it back-to-back → `rd_valid`=1 and `rd_data`=0xBEEF one cycle after the read. Way0/set5/word3 still reads 0.
- **Refill with gap:** `fill_start` set 10/way0, then 8 words 0x1000..0x1007 with a 2-cycle `fill_valid` gap after the 4th word → `fill_busy` for 10 cycles, one `fill_done` pulse. Reads return 0x1000+word.
- **Arbitration:** `fill_start` and `req_valid` in the same cycle → `req_ready`=0, and the request is held until `fill_done`.
- **Reset mid-refill:** assert `rst` after 3 refill words → FSM in IDLE, `fill_done` never pulses, the block reads 0.
- **Parity (`DATA_ARRAY_PARITY_EN`):** force a stored-bit flip via hierarchical force → read gives `rd_perr`=1. A clean read gives 0.
